// File: rtl/i2c_slave_write_burst.sv
// I2C slave-transmitter data path: shifts multi-byte words onto SDA MSB first
// per byte, samples the master's ACK/NACK after each byte and chains words
// through a valid/ready handshake until NACK, data exhaustion or write_en drop.
module i2c_slave_write_burst #(
  parameter int BYTES_PER_WORD = 2,
  parameter bit LSB_BYTE_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        write_en,
  input  logic [8*BYTES_PER_WORD-1:0] data_i,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        byte_done,
  output logic                        word_done,
  output logic                        finish,
  output logic                        nack,
  output logic                        busy
);

  localparam int W   = 8 * BYTES_PER_WORD;
  localparam int BCW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic           scl_last_q;
  logic           ack_bit_q, ack_bit_d;
  logic           sda_q, sda_d;
  logic           nack_q, nack_d;
  logic           byte_done_q, byte_done_d;
  logic           word_done_q, word_done_d;
  logic           finish_q, finish_d;
  logic           load;
  logic           fall, rise;
  logic [W-1:0]   ordered;

  // Rearrange the word so the byte to be sent first sits in the top byte;
  // the shifter then always emits from bit W-1.
  function automatic logic [W-1:0] order_bytes(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = w;
    if (LSB_BYTE_FIRST) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        r[W-1-8*i -: 8] = w[8*i +: 8];
      end
    end
    return r;
  endfunction

  assign fall    = scl_last_q & ~scl_i;
  assign rise    = ~scl_last_q & scl_i;
  assign ordered = order_bytes(data_i);

  // Next-state, bit sequencing and pulse generation.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    ack_bit_d   = ack_bit_q;
    sda_d       = sda_q;
    nack_d      = nack_q;
    byte_done_d = 1'b0;
    word_done_d = 1'b0;
    finish_d    = 1'b0;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        sda_d = 1'b1;
        if (write_en && data_valid) load = 1'b1;
      end
      DATA: begin
        if (!write_en) begin
          sda_d   = 1'b1;
          state_d = IDLE;
        end else if (fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_d   = 1'b1;
            state_d = ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_d     = shift_q[W-1];
            shift_d   = {shift_q[W-2:0], 1'b0};
          end
        end
      end
      ACK: begin
        if (!write_en) begin
          sda_d   = 1'b1;
          state_d = IDLE;
        end else begin
          if (rise) ack_bit_d = sda_i;
          if (fall) begin
            if (ack_bit_q) begin
              nack_d   = 1'b1;
              finish_d = 1'b1;
              sda_d    = 1'b1;
              state_d  = IDLE;
            end else begin
              byte_done_d = 1'b1;
              if (byte_cnt_q != LAST_BYTE) begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
                bit_cnt_d  = 3'd0;
                sda_d      = shift_q[W-1];
                shift_d    = {shift_q[W-2:0], 1'b0};
                state_d    = DATA;
              end else begin
                word_done_d = 1'b1;
                if (data_valid) begin
                  load = 1'b1;
                end else begin
                  finish_d = 1'b1;
                  state_d  = IDLE;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d    = {ordered[W-2:0], 1'b0};
      sda_d      = ordered[W-1];
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      nack_d     = 1'b0;
      state_d    = DATA;
    end
  end

  // Control, SDA drive and pulse registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= '0;
      scl_last_q  <= 1'b1;
      ack_bit_q   <= 1'b1;
      sda_q       <= 1'b1;
      nack_q      <= 1'b0;
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      scl_last_q  <= scl_i;
      ack_bit_q   <= ack_bit_d;
      sda_q       <= sda_d;
      nack_q      <= nack_d;
      byte_done_q <= byte_done_d;
      word_done_q <= word_done_d;
      finish_q    <= finish_d;
    end
  end

  // Data shifter; contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data_ready = rst_n & load;
  assign sda_o      = sda_q;
  assign byte_done  = byte_done_q;
  assign word_done  = word_done_q;
  assign finish     = finish_q;
  assign nack       = nack_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_write_burst.sv
// Bench for i2c_slave_write_burst: two instances (MSB-byte-first and
// LSB-byte-first) share one emulated I2C master.
module tb_i2c_slave_write_burst;

  logic        clk = 1'b0;
  logic        rst_n, write_en, data_valid, scl, m_sda;
  logic [15:0] data_i;
  logic        ready0, sda0, bd0, wd0, fin0, nack0, busy0;
  logic        ready1, sda1, bd1, wd1, fin1, nack1, busy1;

  always #5 clk = ~clk;

  i2c_slave_write_burst #(.BYTES_PER_WORD(2), .LSB_BYTE_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .data_i(data_i),
    .data_valid(data_valid), .data_ready(ready0), .scl_i(scl), .sda_i(m_sda),
    .sda_o(sda0), .byte_done(bd0), .word_done(wd0), .finish(fin0),
    .nack(nack0), .busy(busy0));

  i2c_slave_write_burst #(.BYTES_PER_WORD(2), .LSB_BYTE_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .data_i(data_i),
    .data_valid(data_valid), .data_ready(ready1), .scl_i(scl), .sda_i(m_sda),
    .sda_o(sda1), .byte_done(bd1), .word_done(wd1), .finish(fin1),
    .nack(nack1), .busy(busy1));

  int total = 0;
  int bad   = 0;

  // Running pulse counters, sampled mid-cycle.
  int c_bd = 0, c_wd = 0, c_fin = 0, c_rdy = 0, c_fin1 = 0, c_bd1 = 0;
  always @(negedge clk) begin
    if (bd0)    c_bd++;
    if (wd0)    c_wd++;
    if (fin0)   c_fin++;
    if (ready0) c_rdy++;
    if (fin1)   c_fin1++;
    if (bd1)    c_bd1++;
  end

  logic [15:0] wq [4];
  logic [7:0]  got0 [8];
  logic [7:0]  got1 [8];
  int          nsent;
  int          d_bd, d_wd, d_fin, d_rdy, d_fin1, d_bd1;

  typedef struct {
    logic [15:0] w0, w1;
    int          nw;
    logic [7:0]  mask;
    logic [63:0] e0, e1;
    int          n, bd, wd, rdy;
    logic        nk;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte on the bus plus its ACK slot; returns after the ACK-slot fall.
  task automatic do_byte(input logic ack, output logic [7:0] g0, output logic [7:0] g1);
    for (int i = 7; i >= 0; i--) begin
      tick(2);
      scl = 1'b1;
      tick(2);
      g0[i] = sda0;
      g1[i] = sda1;
      scl = 1'b0;
    end
    tick(2);
    check("ack_release", {30'd0, sda0, sda1}, 32'd3);
    m_sda = ack ? 1'b0 : 1'b1;
    tick(1);
    scl = 1'b1;
    tick(2);
    scl = 1'b0;
    tick(1);
    m_sda = 1'b1;
  endtask

  task automatic run_xfer(input int nw, input logic [7:0] mask);
    int s_bd, s_wd, s_fin, s_rdy, s_fin1, s_bd1;
    logic [7:0] g0, g1;
    s_bd = c_bd; s_wd = c_wd; s_fin = c_fin; s_rdy = c_rdy; s_fin1 = c_fin1; s_bd1 = c_bd1;
    data_i = wq[0];
    data_valid = 1'b1;
    write_en = 1'b1;
    #1;
    check("load_ready", {31'd0, ready0}, 32'd1);
    tick(1);
    if (nw > 1) data_i = wq[1];
    else data_valid = 1'b0;
    nsent = 0;
    for (int b = 0; b < 2 * nw; b++) begin
      do_byte(mask[b], g0, g1);
      got0[b] = g0;
      got1[b] = g1;
      nsent++;
      if (!mask[b]) begin
        data_valid = 1'b0;
        break;
      end
      if (b % 2 == 1) begin
        if (b / 2 + 2 < nw) data_i = wq[b / 2 + 2];
        else data_valid = 1'b0;
      end
    end
    tick(3);
    write_en = 1'b0;
    tick(1);
    d_bd = c_bd - s_bd; d_wd = c_wd - s_wd; d_fin = c_fin - s_fin;
    d_rdy = c_rdy - s_rdy; d_fin1 = c_fin1 - s_fin1; d_bd1 = c_bd1 - s_bd1;
  endtask

  task automatic xfer_check(input string tag, input int nw, input logic [7:0] mask,
                            input logic [63:0] e0, input logic [63:0] e1, input int n,
                            input int ebd, input int ewd, input int erdy, input logic enk);
    run_xfer(nw, mask);
    check({tag, "_nbytes"}, nsent, n);
    for (int k = 0; k < n && k < nsent; k++) begin
      check({tag, "_byte0"}, {24'd0, got0[k]}, {24'd0, e0[63-8*k -: 8]});
      check({tag, "_byte1"}, {24'd0, got1[k]}, {24'd0, e1[63-8*k -: 8]});
    end
    check({tag, "_byte_done"}, d_bd, ebd);
    check({tag, "_byte_done1"}, d_bd1, ebd);
    check({tag, "_word_done"}, d_wd, ewd);
    check({tag, "_finish"}, d_fin, 1);
    check({tag, "_finish1"}, d_fin1, 1);
    check({tag, "_ready"}, d_rdy, erdy);
    check({tag, "_nack"}, {31'd0, nack0}, {31'd0, enk});
    check({tag, "_nack1"}, {31'd0, nack1}, {31'd0, enk});
    check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
    check({tag, "_sda_idle"}, {31'd0, sda0}, 32'd1);
  endtask

  initial begin
    logic [63:0] e0, e1;
    logic [15:0] b0, b1;
    logic [7:0]  mask;
    int          nw, n, ack_cnt, loaded;
    logic        nk;
    int          s_bd, s_wd, s_fin;

    tbl[0] = '{16'h1357, 16'h0000, 1, 8'hFF, 64'h1357_0000_0000_0000, 64'h5713_0000_0000_0000, 2, 2, 1, 1, 1'b0};
    tbl[1] = '{16'h1357, 16'h0000, 1, 8'hFE, 64'h1300_0000_0000_0000, 64'h5700_0000_0000_0000, 1, 0, 0, 1, 1'b1};
    tbl[2] = '{16'h1357, 16'h9bdf, 2, 8'hFF, 64'h1357_9bdf_0000_0000, 64'h5713_df9b_0000_0000, 4, 4, 2, 2, 1'b0};
    tbl[3] = '{16'ha5c3, 16'h0000, 1, 8'hFD, 64'ha5c3_0000_0000_0000, 64'hc3a5_0000_0000_0000, 2, 1, 0, 1, 1'b1};
    tbl[4] = '{16'h0000, 16'hffff, 2, 8'hFB, 64'h0000_ff00_0000_0000, 64'h0000_ff00_0000_0000, 3, 2, 1, 2, 1'b1};

    rst_n = 1'b0; write_en = 1'b1; data_valid = 1'b1; data_i = 16'h1357;
    scl = 1'b0; m_sda = 1'b1;
    #12;
    check("rst_sda", {31'd0, sda0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_nack", {31'd0, nack0}, 32'd0);
    check("rst_pulses", {29'd0, bd0, wd0, fin0}, 32'd0);
    check("rst_ready", {30'd0, ready0, ready1}, 32'd0);
    write_en = 1'b0; data_valid = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    for (int t = 0; t < 5; t++) begin
      wq[0] = tbl[t].w0;
      wq[1] = tbl[t].w1;
      xfer_check($sformatf("vec%0d", t), tbl[t].nw, tbl[t].mask, tbl[t].e0, tbl[t].e1,
                 tbl[t].n, tbl[t].bd, tbl[t].wd, tbl[t].rdy, tbl[t].nk);
      tick(2);
    end

    // Abort coinciding with an SCL fall after two bits: SDA must release.
    s_bd = c_bd; s_wd = c_wd; s_fin = c_fin;
    data_i = 16'h1357; data_valid = 1'b1; write_en = 1'b1;
    tick(1);
    data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(2); scl = 1'b1; tick(2);
      if (i == 1) write_en = 1'b0;
      scl = 1'b0;
    end
    tick(1);
    check("abort_fall_sda", {31'd0, sda0}, 32'd1);
    check("abort_fall_busy", {31'd0, busy0}, 32'd0);
    tick(4);

    // Abort after three bits of 0x13.
    data_i = 16'h1357; data_valid = 1'b1; write_en = 1'b1;
    tick(1);
    data_valid = 1'b0;
    check("abort_load_nack", {31'd0, nack0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(2); scl = 1'b1; tick(2); scl = 1'b0;
    end
    tick(1);
    check("abort_busy_before", {31'd0, busy0}, 32'd1);
    write_en = 1'b0;
    tick(1);
    check("abort_sda", {31'd0, sda0}, 32'd1);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    tick(4);
    check("abort_no_pulses", c_bd - s_bd + c_wd - s_wd + c_fin - s_fin, 0);

    // Reset asserted mid-byte while SDA is driven low.
    data_i = 16'h1357; data_valid = 1'b1; write_en = 1'b1;
    tick(1);
    data_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(2); scl = 1'b1; tick(2); scl = 1'b0;
    end
    tick(1);
    check("rst_mid_sda_before", {31'd0, sda0}, 32'd0);
    data_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sda", {31'd0, sda0}, 32'd1);
    check("rst_mid_busy", {31'd0, busy0}, 32'd0);
    check("rst_mid_pulses", {29'd0, bd0, wd0, fin0}, 32'd0);
    check("rst_mid_ready", {31'd0, ready0}, 32'd0);
    tick(2);
    rst_n = 1'b1; write_en = 1'b0; data_valid = 1'b0;
    tick(2);
    wq[0] = 16'h9bdf;
    xfer_check("after_rst", 1, 8'hFF, 64'h9bdf_0000_0000_0000, 64'hdf9b_0000_0000_0000,
               2, 2, 1, 1, 1'b0);
    tick(2);

    // Randomized bursts against a byte-stream model of the protocol.
    for (int r = 0; r < 20; r++) begin
      nw = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wq[i] = 16'($urandom);
      mask = 8'hFF;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 5) == 0) mask[i] = 1'b0;
      e0 = '0; e1 = '0; n = 0; ack_cnt = 0; loaded = 0; nk = 1'b0;
      for (int wi = 0; wi < nw && !nk; wi++) begin
        loaded++;
        for (int bi = 0; bi < 2 && !nk; bi++) begin
          b0 = (wq[wi] >> (8 * (1 - bi))) & 16'h00ff;
          b1 = (wq[wi] >> (8 * bi)) & 16'h00ff;
          e0[63-8*n -: 8] = b0[7:0];
          e1[63-8*n -: 8] = b1[7:0];
          if (mask[n]) ack_cnt++;
          else nk = 1'b1;
          n++;
        end
      end
      xfer_check($sformatf("rnd%0d", r), nw, mask, e0, e1, n, ack_cnt, ack_cnt / 2, loaded, nk);
      tick($urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
